packnum: RTL and testbench



---
 rtl/num_pkg.sv | 47 ++++
 rtl/packnum_if.sv | 36 +++
 rtl/pack_out_reg.sv | 50 +++++
 rtl/packnum.sv | 167 ++++++++++++++++
 tb/tb_packnum.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/num_pkg.sv
// -----------------------------------------------------------------------------
// num_pkg -- shared definitions for the chunk fetch/pack datapath.
//
// Both the fetch side and the packer import this package so they agree on
// chunk width, chunks per word and chunk order (first chunk in the MSBs).
//
// Contents:
//   CHUNK_W, CHUNKS, WORD_W   geometry of a packed word
//   IDX_W, CNT_W              widths of a chunk index / a chunk count
//   state_e                   packer FSM encoding (FILL, FLUSH)
//   out_beat_t                {cnt, data} held by the output register
//   place_chunk()             positions a chunk at index k of a word
// -----------------------------------------------------------------------------
package num_pkg;

  localparam int CHUNK_W = 5;
  localparam int CHUNKS  = 4;
  localparam int WORD_W  = CHUNK_W * CHUNKS;

  // Index 0..CHUNKS-1 for the fill counter, count 0..CHUNKS for out_cnt.
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CNT_W = $clog2(CHUNKS + 1);

  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef struct packed {
    cnt_t  cnt;
    word_t data;
  } out_beat_t;

  // Chunk k occupies word[WORD_W-1-k*CHUNK_W -: CHUNK_W]: start in the MSBs
  // and shift right by k chunk positions.
  function automatic word_t place_chunk(input chunk_t chunk, input idx_t idx);
    word_t w;
    w = {chunk, {(WORD_W - CHUNK_W){1'b0}}};
    return w >> (int'(idx) * CHUNK_W);
  endfunction

endpackage : num_pkg

// File: rtl/packnum_if.sv
// -----------------------------------------------------------------------------
// packnum_if -- chunk input and packed-word output handshakes of packnum.
//
// Signals:
//   in_valid / in_data / in_ready   chunk stream into the packer
//   flush                           one-cycle pulse, emit pending partial word
//   out_valid / out_ready           packed-word handshake
//   out_data / out_cnt              packed word and number of valid chunks
//
// Modports:
//   master  the environment: drives chunks, flush and out_ready
//   slave   the packer itself
// -----------------------------------------------------------------------------
interface packnum_if;
  import num_pkg::*;

  logic   in_valid;
  chunk_t in_data;
  logic   in_ready;
  logic   flush;
  logic   out_valid;
  logic   out_ready;
  word_t  out_data;
  cnt_t   out_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );

endinterface : packnum_if

// File: rtl/pack_out_reg.sv
// -----------------------------------------------------------------------------
// pack_out_reg -- single-entry valid/ready register holding {out_cnt, out_data}.
//
// The parent only asserts load_i when the register is free this cycle
// (empty, or draining through out_ready_i), so a load never overwrites an
// undelivered beat. Load and drain in the same cycle keep out_valid high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_i            capture load_beat_i at this edge
//   load_beat_i       beat to capture
//   out_ready_i       sink accepts the current beat
//   out_valid_o       beat held and valid
//   out_beat_o        held beat, stable while out_valid_o && !out_ready_i
// -----------------------------------------------------------------------------
module pack_out_reg
  import num_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  out_beat_t load_beat_i,
  input  logic      out_ready_i,
  output logic      out_valid_o,
  output out_beat_t out_beat_o
);

  logic      valid_q;
  out_beat_t beat_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  // The data register is reset too, so out_data reads 0 after reset rather
  // than a stale word from before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      beat_q  <= load_beat_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_beat_o  = beat_q;

endmodule : pack_out_reg

// File: rtl/packnum.sv
// -----------------------------------------------------------------------------
// packnum -- chunk packer, write-side counterpart of the chunk fetch.
//
// Collects CHUNKS consecutive CHUNK_W-bit numbers MSB-first into one
// WORD_W-bit word and hands it to a single-entry valid/ready output register.
// A flush pulse emits a zero-padded partial word; if the output register is
// still occupied the partial word is parked (FLUSH state) until it frees up.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   packnum_if.slave: in_valid/in_data/in_ready, flush,
//         out_valid/out_ready/out_data/out_cnt
// -----------------------------------------------------------------------------
module packnum
  import num_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  packnum_if.slave        bus
);

  localparam idx_t LAST_IDX = idx_t'(CHUNKS - 1);

  state_e    state_q, state_d;
  word_t     acc_q, acc_d;
  idx_t      cnt_q, cnt_d;

  logic      out_valid;
  out_beat_t out_beat;
  logic      load;
  out_beat_t load_beat;

  logic      in_ready;
  logic      out_free;
  logic      accept;
  logic      full_accept;
  word_t     acc_c;
  cnt_t      cnt_c;

  // Output register empties or drains at this edge.
  assign out_free = !out_valid || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // The final chunk of a word can only be taken when the output register
  // can take the completed word at the same edge.
  assign full_accept = accept && (cnt_q == LAST_IDX);

  // Accumulator and count as they stand including this cycle's chunk.
  assign acc_c = accept ? (acc_q | place_chunk(bus.in_data, cnt_q)) : acc_q;
  assign cnt_c = cnt_t'(cnt_q) + cnt_t'(accept);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable an always_comb writes gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        // Partial flush that cannot be emitted now: park it.
        if (bus.flush && !full_accept && (cnt_c != '0) && !out_free) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      FILL:    in_ready = (cnt_q != LAST_IDX) || out_free;
      FLUSH:   in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Accumulator update and output-register load.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_beat = '0;
    unique case (state_q)
      FILL: begin
        if (full_accept) begin
          load           = 1'b1;
          load_beat.data = acc_c;
          load_beat.cnt  = cnt_t'(CHUNKS);
          acc_d          = '0;
          cnt_d          = '0;
        end else if (bus.flush && (cnt_c != '0)) begin
          if (out_free) begin
            load           = 1'b1;
            load_beat.data = acc_c;
            load_beat.cnt  = cnt_c;
            acc_d          = '0;
            cnt_d          = '0;
          end else begin
            // cnt_c < CHUNKS here, so it fits the index counter and is held
            // there until the FLUSH state can emit it.
            acc_d = acc_c;
            cnt_d = cnt_c[IDX_W-1:0];
          end
        end else begin
          acc_d = acc_c;
          cnt_d = cnt_c[IDX_W-1:0];
        end
      end
      FLUSH: begin
        if (out_free) begin
          load           = 1'b1;
          load_beat.data = acc_q;
          load_beat.cnt  = cnt_t'(cnt_q);
          acc_d          = '0;
          cnt_d          = '0;
        end
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  pack_out_reg u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .load_beat_i (load_beat),
    .out_ready_i (bus.out_ready),
    .out_valid_o (out_valid),
    .out_beat_o  (out_beat)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_beat.data;
  assign bus.out_cnt   = out_beat.cnt;

endmodule : packnum

// File: tb/tb_packnum.sv
// -----------------------------------------------------------------------------
// tb_packnum -- self-checking bench for packnum.
//
// A reference model tracks accepted chunks as a list and the words owed to
// the sink as a queue; every delivered word is compared against it. Directed
// steps cover the packing scenarios with fixed values, then a random phase
// exercises backpressure and flush interleavings.
// -----------------------------------------------------------------------------
module tb_packnum;
  import num_pkg::*;

  typedef struct {
    logic [WORD_W-1:0] data;
    int                cnt;
  } exp_word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  packnum_if bus();

  packnum u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CHUNK_W-1:0] pend_q[$];   // chunks accepted into the current word
  exp_word_t          exp_q[$];    // words emitted but not yet delivered

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word built from a list of chunks: chunk i sits i chunk widths below the top.
  function automatic logic [WORD_W-1:0] model_word(input logic [CHUNK_W-1:0] q[$]);
    logic [WORD_W-1:0] w = '0;
    for (int i = 0; i < q.size(); i++)
      w = w | (WORD_W'(q[i]) << (WORD_W - CHUNK_W * (i + 1)));
    return w;
  endfunction

  task automatic emit_model();
    exp_word_t e;
    e.data = model_word(pend_q);
    e.cnt  = pend_q.size();
    exp_q.push_back(e);
    pend_q.delete();
  endtask

  // Reference model, evaluated mid-cycle where all inputs and outputs are
  // settled for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      check("out_valid_vs_model", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() == 0) check("in_ready_when_idle", 32'(bus.in_ready), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          check("word_data", 32'(bus.out_data), 32'(exp_q[0].data));
          check("word_cnt",  32'(bus.out_cnt),  32'(exp_q[0].cnt));
          void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) pend_q.push_back(bus.in_data);
      if (pend_q.size() == CHUNKS) emit_model();
      else if (bus.flush && pend_q.size() != 0) emit_model();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CHUNK_W-1:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int n_acc;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_cnt",   32'(bus.out_cnt),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // Basic pack
    send(5'h1F); send(5'h00); send(5'h15); send(5'h0A);
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic_data",  32'(bus.out_data),  32'h0F82AA);
    check("basic_cnt",   32'(bus.out_cnt),   32'd4);
    step();
    check("basic_one_cycle", 32'(bus.out_valid), 32'd0);

    // Partial flush, then a flush with nothing pending
    send(5'h03); send(5'h04);
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    check("partial_data", 32'(bus.out_data), 32'h19000);
    check("partial_cnt",  32'(bus.out_cnt),  32'd2);
    step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    check("empty_flush_no_word", 32'(bus.out_valid), 32'd0);
    step();
    check("empty_flush_still_idle", 32'(bus.out_valid), 32'd0);

    // Backpressure: chunks 1..8 offered, only 7 fit while the sink stalls
    bus.out_ready = 1'b0;
    k = 1;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = CHUNK_W'(k);
      #1;
      if (bus.in_ready && k <= 8) begin
        n_acc++;
        k++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_accepted",  32'(n_acc),          32'd7);
    check("bp_in_ready",  32'(bus.in_ready),   32'd0);
    check("bp_held_data", 32'(bus.out_data),   32'h08864);
    check("bp_held_cnt",  32'(bus.out_cnt),    32'd4);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    check("bp_second_data", 32'(bus.out_data), 32'h298E8);
    check("bp_second_cnt",  32'(bus.out_cnt),  32'd4);
    step();

    // Flush blocked behind a held word
    bus.out_ready = 1'b0;
    send(5'h01); send(5'h02); send(5'h03); send(5'h04);
    send(5'h11);
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    check("fb_in_ready",  32'(bus.in_ready), 32'd0);
    step(); step();
    check("fb_still_blocked", 32'(bus.in_ready), 32'd0);
    check("fb_held_cnt",      32'(bus.out_cnt),  32'd4);
    bus.out_ready = 1'b1;
    step();
    check("fb_data",     32'(bus.out_data),  32'h88000);
    check("fb_cnt",      32'(bus.out_cnt),   32'd1);
    check("fb_in_ready_back", 32'(bus.in_ready), 32'd1);
    step();

    // Flush together with the third chunk
    send(5'h01); send(5'h02);
    bus.flush = 1'b1;
    send(5'h03);
    bus.flush = 1'b0;
    check("sim_data", 32'(bus.out_data), 32'h08860);
    check("sim_cnt",  32'(bus.out_cnt),  32'd3);
    step();

    // Reset in the middle of a word
    send(5'h07); send(5'h09);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    send(5'h1F); send(5'h00); send(5'h15); send(5'h0A);
    check("after_rst_data", 32'(bus.out_data), 32'h0F82AA);
    check("after_rst_cnt",  32'(bus.out_cnt),  32'd4);
    step();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = CHUNK_W'($urandom);
      bus.flush     = ($urandom_range(0, 7) == 0);
      bus.out_ready = (i % 200 < 30) ? ($urandom_range(0, 5) == 0)
                                     : ($urandom_range(0, 2) != 0);
      step();
    end

    // Drain everything still owed
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    step(); step(); step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    check("drain_all_words", 32'(exp_q.size()),  32'd0);
    check("drain_no_pending", 32'(pend_q.size()), 32'd0);
    check("drain_idle", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_packnum
